// File: rtl/r3_sdf_bf.sv
// r3_sdf_bf -- radix-3 single-delay-feedback butterfly stage.
//
// Holds the first two thirds of each 3*D-sample frame in two D-deep feedback
// delay lines (FA, FB). During the last third it forms the 3-point DFT and
// emits X0 directly. X1 and X2 go back into FA/FB and are emitted during the
// first two thirds of the following frame.
//
// Parameters
//   W : width of each real/imaginary component (signed)
//   D : butterfly span / delay-line depth, frame length is 3*D (D >= 1)
//   K : sqrt(3)/2 in Q1.15
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input sample present; all state advances only when high
//   a_re/a_img input sample
//   out_valid  registered output valid
//   out_sop    high with X0 of index 0 of each frame
//   a1_re/a1_img registered output sample (held while out_valid is low)

module r3_sdf_bf #(
    parameter int W = 32,
    parameter int D = 9,
    parameter int K = 28378
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_img,
    output logic                out_valid,
    output logic                out_sop,
    output logic signed [W-1:0] a1_re,
    output logic signed [W-1:0] a1_img
);

    localparam int EW = W + 18;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2
    } phase_t;

    phase_t          phase;
    logic [IW-1:0]   idx;
    logic            primed;

    // Delay lines: index 0 is the head (oldest entry).
    logic signed [W-1:0] fa_re [D];
    logic signed [W-1:0] fa_im [D];
    logic signed [W-1:0] fb_re [D];
    logic signed [W-1:0] fb_im [D];

    logic                accept;
    assign accept = in_valid && !rst;

    // ------------------------------------------------------------------
    // Butterfly arithmetic (a = FA head, b = FB head, c = input)
    // ------------------------------------------------------------------
    logic signed [EW-1:0] ar, ai, br, bi, cr, ci;
    logic signed [EW-1:0] sr, si, dr, di, hr, hi;
    logic signed [EW-1:0] pr, pim;
    logic signed [EW-1:0] x0r, x0i, x1r, x1i, x2r, x2i;
    logic signed [EW-1:0] kc;

    always_comb begin
        kc  = EW'(K);
        ar  = {{18{fa_re[0][W-1]}}, fa_re[0]};
        ai  = {{18{fa_im[0][W-1]}}, fa_im[0]};
        br  = {{18{fb_re[0][W-1]}}, fb_re[0]};
        bi  = {{18{fb_im[0][W-1]}}, fb_im[0]};
        cr  = {{18{a_re[W-1]}}, a_re};
        ci  = {{18{a_img[W-1]}}, a_img};

        sr  = br + cr;
        si  = bi + ci;
        dr  = br - cr;
        di  = bi - ci;
        hr  = sr >>> 1;
        hi  = si >>> 1;
        pr  = (kc * dr) >>> 15;
        pim = (kc * di) >>> 15;

        x0r = ar + br + cr;
        x0i = ai + bi + ci;
        x1r = ar - hr + pim;
        x1i = ai - hi - pr;
        x2r = ar - hr - pim;
        x2i = ai - hi + pr;
    end

    // Only the low W bits of each result are kept (wrap-around).
    logic sink_unused;
    assign sink_unused = ^{x0r[EW-1:W], x0i[EW-1:W], x1r[EW-1:W], x1i[EW-1:W],
                           x2r[EW-1:W], x2i[EW-1:W]};

    // ------------------------------------------------------------------
    // Delay-line inputs and output selection
    // ------------------------------------------------------------------
    logic signed [W-1:0] fa_in_re, fa_in_im, fb_in_re, fb_in_im;
    logic signed [W-1:0] nxt_re, nxt_im;

    always_comb begin
        fa_in_re = x1r[W-1:0];
        fa_in_im = x1i[W-1:0];
        fb_in_re = x2r[W-1:0];
        fb_in_im = x2i[W-1:0];
        nxt_re   = x0r[W-1:0];
        nxt_im   = x0i[W-1:0];
        case (phase)
            PH0: begin
                fa_in_re = a_re;
                fa_in_im = a_img;
                nxt_re   = fa_re[0];
                nxt_im   = fa_im[0];
            end
            PH1: begin
                fb_in_re = a_re;
                fb_in_im = a_img;
                nxt_re   = fb_re[0];
                nxt_im   = fb_im[0];
            end
            default: ;
        endcase
    end

    // FA shifts in phases 0 and 2, FB in phases 1 and 2. Contents are not
    // reset: anything stale is masked by primed until a full frame passes.
    always_ff @(posedge clk) begin
        if (accept && phase != PH1) begin
            for (int unsigned i = 0; i + 1 < D; i++) begin
                fa_re[i] <= fa_re[i+1];
                fa_im[i] <= fa_im[i+1];
            end
            fa_re[D-1] <= fa_in_re;
            fa_im[D-1] <= fa_in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && phase != PH0) begin
            for (int unsigned i = 0; i + 1 < D; i++) begin
                fb_re[i] <= fb_re[i+1];
                fb_im[i] <= fb_im[i+1];
            end
            fb_re[D-1] <= fb_in_re;
            fb_im[D-1] <= fb_in_im;
        end
    end

    // ------------------------------------------------------------------
    // Counters, priming and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            phase     <= PH0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            a1_re     <= '0;
            a1_img    <= '0;
        end else begin
            out_valid <= in_valid && (primed || phase == PH2);
            out_sop   <= in_valid && phase == PH2 && idx == '0;
            if (in_valid) begin
                a1_re  <= nxt_re;
                a1_img <= nxt_im;
                if (phase == PH2)
                    primed <= 1'b1;
                if (idx == IDX_LAST) begin
                    idx <= '0;
                    case (phase)
                        PH0:     phase <= PH1;
                        PH1:     phase <= PH2;
                        default: phase <= PH0;
                    endcase
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_r3_sdf_bf.sv
// Self-checking bench for r3_sdf_bf. Three instances (D=1, D=3, D=9) share
// the data/reset bus; sel chooses which one sees in_valid and which one's
// outputs are observed. Expected streams come from a frame-level model of
// the 3-point DFT and the X0 / X1(prev) / X2(prev) output ordering.

module tb_r3_sdf_bf;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
        logic        sop;
    } smp_t;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cx_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic vin = 1'b0;
    logic signed [31:0] din_re = '0;
    logic signed [31:0] din_im = '0;
    int sel = 9;

    logic v1, v3, v9;
    logic ov1, ov3, ov9, sp1, sp3, sp9;
    logic signed [31:0] re1, re3, re9, im1, im3, im9;
    logic ov, osop;
    logic signed [31:0] ore, oim;

    int errors = 0;
    int checks = 0;

    cx_t  stim_q[$];
    smp_t got_q[$];
    smp_t exp_q[$];

    always #5 clk = ~clk;

    assign v1 = vin && sel == 1;
    assign v3 = vin && sel == 3;
    assign v9 = vin && sel == 9;

    always_comb begin
        case (sel)
            1:       begin ov = ov1; osop = sp1; ore = re1; oim = im1; end
            3:       begin ov = ov3; osop = sp3; ore = re3; oim = im3; end
            default: begin ov = ov9; osop = sp9; ore = re9; oim = im9; end
        endcase
    end

    r3_sdf_bf #(.W(32), .D(1), .K(28378)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a_re(din_re), .a_img(din_im),
        .out_valid(ov1), .out_sop(sp1), .a1_re(re1), .a1_img(im1));
    r3_sdf_bf #(.W(32), .D(3), .K(28378)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(v3), .a_re(din_re), .a_img(din_im),
        .out_valid(ov3), .out_sop(sp3), .a1_re(re3), .a1_img(im3));
    r3_sdf_bf #(.W(32), .D(9), .K(28378)) u_d9 (
        .clk(clk), .rst(rst), .in_valid(v9), .a_re(din_re), .a_img(din_im),
        .out_valid(ov9), .out_sop(sp9), .a1_re(re9), .a1_img(im9));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // 3-point DFT of samples (base, base+d, base+2d) of the accepted stream.
    function automatic void bf(input int base, input int d,
                               output smp_t x0, output smp_t x1, output smp_t x2);
        longint a_r, a_i, b_r, b_i, c_r, c_i, h_r, h_i, p_r, p_i;
        a_r = longint'($signed(stim_q[base].re));
        a_i = longint'($signed(stim_q[base].im));
        b_r = longint'($signed(stim_q[base+d].re));
        b_i = longint'($signed(stim_q[base+d].im));
        c_r = longint'($signed(stim_q[base+2*d].re));
        c_i = longint'($signed(stim_q[base+2*d].im));
        h_r = (b_r + c_r) >>> 1;
        h_i = (b_i + c_i) >>> 1;
        p_r = (longint'(28378) * (b_r - c_r)) >>> 15;
        p_i = (longint'(28378) * (b_i - c_i)) >>> 15;
        x0.re = 32'(a_r + b_r + c_r);
        x0.im = 32'(a_i + b_i + c_i);
        x0.sop = 1'b0;
        x1.re = 32'(a_r - h_r + p_i);
        x1.im = 32'(a_i - h_i - p_r);
        x1.sop = 1'b0;
        x2.re = 32'(a_r - h_r - p_i);
        x2.im = 32'(a_i - h_i + p_r);
        x2.sop = 1'b0;
    endfunction

    // Output for each accepted sample: third 2 gives X0 of this frame,
    // thirds 0/1 give X1/X2 of the previous frame (none for frame 0).
    task automatic build_model(input int d);
        exp_q.delete();
        for (int n = 0; n < stim_q.size(); n++) begin
            int f, r, p, j;
            smp_t x0, x1, x2;
            f = n / (3 * d);
            r = n % (3 * d);
            p = r / d;
            j = r % d;
            if (p == 2) begin
                bf(f * 3 * d + j, d, x0, x1, x2);
                x0.sop = (j == 0);
                exp_q.push_back(x0);
            end else if (f > 0) begin
                bf((f - 1) * 3 * d + j, d, x0, x1, x2);
                if (p == 0) exp_q.push_back(x1);
                else        exp_q.push_back(x2);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic step(input bit v, input logic [31:0] re, input logic [31:0] im);
        vin    = v;
        din_re = re;
        din_im = im;
        if (v && !rst) stim_q.push_back('{re: re, im: im});
        @(posedge clk);
        #1;
        if (ov) got_q.push_back('{re: ore, im: oim, sop: osop});
        vin = 1'b0;
    endtask

    task automatic do_reset();
        vin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        stim_q.delete();
        got_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        vin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = (s == 0) ? 1 : (s == 1) ? 3 : 9;
            #1;
            checks++;
            if (ov !== 1'b0 || osop !== 1'b0 || ore !== 0 || oim !== 0) begin
                errors++;
                $display("FAIL reset_D%0d got v=%b sop=%b (%0d,%0d) want v=0 sop=0 (0,0)",
                         sel, ov, osop, ore, oim);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_d1_basic();
        sel = 1;
        do_reset();
        step(1, 1000, 0);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL d1_prime0 got v=%b want 0", ov); end
        step(1, 2000, 0);
        checks++;
        if (ov !== 1'b0) begin errors++; $display("FAIL d1_prime1 got v=%b want 0", ov); end
        step(1, 3000, 0);
        checks++;
        if (ov !== 1'b1 || osop !== 1'b1 || ore !== 6000 || oim !== 0) begin
            errors++;
            $display("FAIL d1_x0 got v=%b sop=%b (%0d,%0d) want v=1 sop=1 (6000,0)",
                     ov, osop, ore, oim);
        end
        step(1, 0, 0);
        checks++;
        if (ov !== 1'b1 || osop !== 1'b0 || ore !== -1500 || oim !== 867) begin
            errors++;
            $display("FAIL d1_x1 got v=%b sop=%b (%0d,%0d) want v=1 sop=0 (-1500,867)",
                     ov, osop, ore, oim);
        end
        step(1, 0, 0);
        checks++;
        if (ov !== 1'b1 || osop !== 1'b0 || ore !== -1500 || oim !== -867) begin
            errors++;
            $display("FAIL d1_x2 got v=%b sop=%b (%0d,%0d) want v=1 sop=0 (-1500,-867)",
                     ov, osop, ore, oim);
        end
        step(0, 32'h1234, 32'h5678);
        checks++;
        if (ov !== 1'b0 || osop !== 1'b0 || ore !== -1500 || oim !== -867) begin
            errors++;
            $display("FAIL d1_hold got v=%b sop=%b (%0d,%0d) want v=0 sop=0 (-1500,-867)",
                     ov, osop, ore, oim);
        end
    endtask

    task automatic test_d3_frame();
        sel = 3;
        do_reset();
        for (int k = 1; k <= 9; k++) step(1, k, -k);
        for (int k = 0; k < 6; k++) step(1, 0, 0);
        build_model(3);
        checks++;
        if (got_q.size() != 9 || exp_q.size() != 9) begin
            errors++;
            $display("FAIL d3_count got %0d model %0d want 9", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            checks++;
            if ($signed(got_q[i].re) !== 12 + 3 * i || $signed(got_q[i].im) !== -(12 + 3 * i)) begin
                errors++;
                $display("FAIL d3_x0[%0d] got (%0d,%0d) want (%0d,%0d)", i,
                         $signed(got_q[i].re), $signed(got_q[i].im), 12 + 3 * i, -(12 + 3 * i));
            end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL d3_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        sel = 1;
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 32'h7FFFFFFF, 32'h80000000);
        checks++;
        if (ov !== 1'b1 || ore !== 32'sh7FFFFFFD || oim !== 32'sh80000000) begin
            errors++;
            $display("FAIL ovf_x0 got v=%b (%h,%h) want v=1 (7ffffffd,80000000)", ov, ore, oim);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        build_model(1);
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL ovf_count got %0d want 3", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gaps();
        int n;
        sel = 9;
        do_reset();
        n = 0;
        while (n < 20 * 27 + 18) begin
            if ($urandom_range(1, 0) == 1) begin
                if (n < 20 * 27) step(1, $urandom, $urandom);
                else             step(1, 0, 0);
                n++;
            end else begin
                step(0, $urandom, $urandom);
            end
        end
        build_model(9);
        checks++;
        if (got_q.size() != stim_q.size() - 18 || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count got %0d want %0d", got_q.size(), stim_q.size() - 18);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_at;
        sel = 9;
        do_reset();
        for (int k = 0; k < 13; k++) step(1, $urandom, $urandom);
        // Sample at phase 1, idx 4 arrives together with reset: it is dropped.
        rst = 1'b1;
        step(1, $urandom, $urandom);
        rst = 1'b0;
        checks++;
        if (got_q.size() != 0 || ov !== 1'b0 || ore !== 0 || oim !== 0) begin
            errors++;
            $display("FAIL rmid_reset got outs=%0d v=%b (%0d,%0d) want 0 v=0 (0,0)",
                     got_q.size(), ov, ore, oim);
        end
        stim_q.delete();
        got_q.delete();
        first_at = -1;
        for (int k = 0; k < 27 + 18; k++) begin
            if (k < 27) step(1, $urandom, $urandom);
            else        step(1, 0, 0);
            if (first_at < 0 && got_q.size() > 0) first_at = stim_q.size();
        end
        build_model(9);
        checks++;
        if (first_at != 19) begin
            errors++;
            $display("FAIL rmid_first got first output after %0d samples want 19", first_at);
        end
        checks++;
        if (got_q.size() == 0 || got_q[0].sop !== 1'b1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rmid_sop got %h want %h", (got_q.size() > 0) ? got_q[0] : '0, exp_q[0]);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rmid_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rmid_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        sel = 9;
        do_reset();
        for (int n = 0; n < 100 * 27 + 18; n++) begin
            if (n < 100 * 27) step(1, $urandom, $urandom);
            else              step(1, 0, 0);
        end
        build_model(9);
        checks++;
        if (got_q.size() != 100 * 27 || exp_q.size() != 100 * 27) begin
            errors++;
            $display("FAIL b2b_count got %0d want %0d", got_q.size(), 100 * 27);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_stream[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].sop !== ((i % 27) == 0)) begin
                errors++;
                $display("FAIL b2b_sop[%0d] got %b want %b", i, got_q[i].sop, (i % 27) == 0);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_d1_basic();
        test_d3_frame();
        test_overflow();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/r3_sdf_bf.md
# r3_sdf_bf

Radix-3 single-delay-feedback (SDF) butterfly stage for the radix-3² FFT pipeline. It accepts one complex sample per valid cycle and holds the first two thirds of each 3·D-sample frame in two internal feedback delay lines. When the third thirds arrive, it computes the 3-point DFT and emits X0 directly. X1 and X2 recirculate through the delay lines and are emitted during the next frame. It sits directly upstream of the fixed-length delay buffers and twiddle multipliers that realign its output stream.

## Interface
- W, 32: width of each real/imaginary component (signed two's complement).
- D, 9: butterfly span / delay-line depth in samples. Frame length is 3·D; D ≥ 1.
- K, 28378: √3/2 in Q1.15, applied with an arithmetic shift right of 15.

- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high).
- in_valid  in  1  input sample present this cycle. The stage advances only when this is high.
- a_re  in  W  input real part.
- a_img  in  W  input imaginary part.
- out_valid  out  1  output sample valid.
- out_sop  out  1  high with the X0 output for index 0 of each frame.
- a1_re  out  W  output real part.
- a1_img  out  W  output imaginary part.

## Operation
- Counters:
  - idx counts 0..D-1 and phase counts 0..2.
  - Both advance only on accepted samples (in_valid=1).
  - idx wraps to 0 and then phase increments; phase wraps 2→0.
- Delay lines:
  - FA and FB are D-deep complex shift registers.
  - FA shifts only on accepted samples in phase 0 or 2.
  - FB shifts only on accepted samples in phase 1 or 2.
  - Head = oldest entry.
- Phase 0:
  - push input into FA (this is a);
  - output = FA head (X1 of the previous frame, same idx).
- Phase 1:
  - push input into FB (this is b);
  - output = FB head (X2 of the previous frame).
- Phase 2, with a = FA head, b = FB head, c = input:
  - output X0;
  - push X1 into FA and X2 into FB.
- Arithmetic (all intermediates W+18 bits signed; results truncated to the low W bits, i.e. wrap, no saturation):
  - s = b+c, d = b−c, h = s >>> 1 per component.
  - pr = (K·d.re) >>> 15, pi = (K·d.im) >>> 15 (floor).
  - X0 = a+b+c.
  - X1.re = a.re − h.re + pi, X1.im = a.im − h.im − pr.
  - X2.re = a.re − h.re − pi, X2.im = a.im − h.im + pr.
- Priming:
  - The primed flag is set by the first accepted phase-2 sample after reset.
  - out_valid = accepted sample AND (primed OR current phase is 2).
  - Phase-0/1 outputs of the very first frame are therefore suppressed.
- Draining: after the last real frame, the driver supplies 2·D further valid samples (zeros) to flush X1/X2.
- Reset:
  - idx=0, phase=0, primed=0, out_valid=0, out_sop=0, a1_re=0, a1_img=0.
  - FA/FB contents are not reset; stale data is masked by primed=0.
  - Reset mid-frame discards the partial frame; the next accepted sample is phase 0, idx 0.
- Back-to-back frames need no gap. in_valid may drop at any cycle; state then freezes with no shift and no counter change.

## Timing
- All outputs are registered, with a one-cycle latency from the accepting edge to the output.
- When in_valid=0, the next cycle has out_valid=0, out_sop=0, and a1_re/a1_img hold their previous values.
- out_sop=1 exactly when out_valid=1, the source sample was phase 2, and idx=0.
- Latency from input a(k) to X0(k): 2·D accepted samples + 1 cycle. X1(k) follows 3·D accepted samples + 1 cycle after a(k); X2(k) follows 4·D + 1.
- A reset asserted in the same cycle as in_valid wins: the sample is dropped.
- Throughput: one sample per clock, sustained.

## Test plan
- D=1, inputs (1000,0),(2000,0),(3000,0) on consecutive cycles, then (0,0)×2 → one cycle after the third input: out_valid=1, out_sop=1, output (6000,0). Then (−1500,867), then (−1500,−867). The first two cycles show out_valid=0.
- D=3, frame of nine samples of (k,−k) with k=1..9, then 6 zeros → X0 for idx 0..2 = (12,−12),(15,−15),(18,−18). Following X1/X2 values match the formulas bit-exactly against a reference model.
- Random in_valid gaps (50% duty) over 20 frames with D=9 → the output sequence is identical to the gapless run; out_valid count equals accepted count minus 2·D.
- Reset asserted in phase 1, idx 4 (D=9), then a fresh frame → no out_valid until that frame's phase 2. First output is out_sop=1 with the new frame's X0(0).
- Overflow: a=b=c=(2^31−1, −2^31) → X0 wraps to the low-32-bit truncation of 3·a: (0x7FFFFFFD, 0x80000000).
- Continuous full-rate random stimulus, 100 frames → bit-exact match against the reference model; out_sop every 3·D valid outputs.
